// File: rtl/uart_tx_ctrl_pkg.sv
// uart_pkg: shared definitions for the UART transmit controller.
//   - tx_state_t : FSM state encoding (3 bits)
//   - DEF_CLKS_PER_BIT / DEF_DATA_BITS : default build constants
//   - frame_cycles() : total frame length in clk cycles
package uart_pkg;

  localparam int unsigned DEF_CLKS_PER_BIT = 10;
  localparam int unsigned DEF_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Start + data + optional parity + stop, each lasting clks cycles.
  function automatic int unsigned frame_cycles(input int unsigned clks,
                                               input int unsigned dbits,
                                               input bit          parity);
    return (dbits + 2 + (parity ? 1 : 0)) * clks;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_baud_tick_gen.sv
// baud_tick_gen: bit-period timer for the UART transmitter.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   enable in   count while high; counter cleared while low
//   tick   out  high on the last cycle of each bit period (combinational)
module baud_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = uart_pkg::DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign tick = enable && (count == LAST);

  // Counter runs 0..CLKS_PER_BIT-1 and wraps on tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit controller. Accepts a word on tx_start while
// idle and sends start bit, LSB-first data, optional even parity, stop bit.
// Optional feature: define UART_TX_PARITY_EN to insert an even parity bit.
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   tx_start  in   send request, sampled only in IDLE
//   tx_data   in   word to send, captured when tx_start is accepted
//   tx_serial out  serial line, idle high (registered)
//   tx_busy   out  frame in progress (registered)
//   tx_done   out  one-cycle pulse at frame end (registered)
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [IDX_W-1:0]     bit_idx;
  logic                 baud_tick;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  // Bit timer only runs while a frame is on the line.
  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .enable (state != IDLE),
    .tick   (baud_tick)
  );

  // Frame sequencer; tx_serial is loaded with the level of the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      tx_serial <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_serial <= 1'b1;
          tx_busy   <= 1'b0;
          if (tx_start) begin
            shift_reg <= tx_data;
            bit_idx   <= '0;
            state     <= START;
            tx_serial <= 1'b0;
            tx_busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            // Captured here because the shift register is consumed during DATA.
            parity_bit <= ^tx_data;
`endif
          end
        end
        START: begin
          if (baud_tick) begin
            state     <= DATA;
            tx_serial <= shift_reg[0];
          end
        end
        DATA: begin
          if (baud_tick) begin
            shift_reg <= shift_reg >> 1;
            bit_idx   <= bit_idx + IDX_W'(1);
            if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              state     <= PARITY;
              tx_serial <= parity_bit;
`else
              state     <= STOP;
              tx_serial <= 1'b1;
`endif
            end else begin
              // Next bit sits at [1] until the shift lands this edge.
              tx_serial <= shift_reg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_tick) begin
            state     <= STOP;
            tx_serial <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_tick) begin
            state     <= IDLE;
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          tx_serial <= 1'b1;
          tx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: self-checking bench for uart_tx_ctrl against a line-level
// waveform model built from the frame format.
// Honours UART_TX_PARITY_EN when defined for the build.
module tb_uart_tx_ctrl;

  localparam int unsigned C  = 10;
  localparam int unsigned DB = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_start;
  logic [DB-1:0] tx_data;
  logic          tx_serial;
  logic          tx_busy;
  logic          tx_done;

  int total = 0;
  int bad   = 0;

  bit exp_wave[$];

  uart_tx_ctrl #(
    .CLKS_PER_BIT(C),
    .DATA_BITS   (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  // Reference: expected line level for each cycle of a frame carrying d.
  function automatic void build_wave(input logic [DB-1:0] d);
    bit lvl[$];
    exp_wave.delete();
    lvl.push_back(1'b0);
    for (int i = 0; i < int'(DB); i++) lvl.push_back(d[i]);
    if (PAR) lvl.push_back(^d);
    lvl.push_back(1'b1);
    foreach (lvl[b])
      for (int c = 0; c < int'(C); c++) exp_wave.push_back(lvl[b]);
  endfunction

  // Present a request so it is sampled on the next rising edge.
  task automatic start_frame(input logic [DB-1:0] d);
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = d;
    @(posedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; tx_start = 1'b0; tx_data = '0;
    repeat (2) @(negedge clk);
    total++;
    if (tx_serial !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_values serial=%b busy=%b done=%b want 1/0/0", tx_serial, tx_busy, tx_done);
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      total++;
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
        bad++;
        $display("FAIL idle_hold cyc=%0d serial=%b busy=%b done=%b want 1/0/0", k, tx_serial, tx_busy, tx_done);
      end
    end
  endtask

  // One frame, with tx_data scrambled right after acceptance.
  task automatic test_frame(input logic [DB-1:0] d);
    int busy_cnt;
    int exp_len;
    build_wave(d);
    exp_len  = int'(uart_pkg::frame_cycles(C, DB, PAR));
    busy_cnt = 0;
    start_frame(d);
    for (int k = 0; k < exp_wave.size(); k++) begin
      @(negedge clk);
      if (k == 0) begin
        tx_start = 1'b0;
        tx_data  = DB'($urandom);
      end
      if (tx_busy === 1'b1) busy_cnt++;
      total++;
      if (tx_serial !== exp_wave[k] || tx_done !== 1'b0) begin
        bad++;
        $display("FAIL frame_line d=%h cyc=%0d serial=%b done=%b want %b/0", d, k, tx_serial, tx_done, exp_wave[k]);
      end
    end
    @(negedge clk);
    total++;
    if (tx_done !== 1'b1 || tx_busy !== 1'b0 || tx_serial !== 1'b1) begin
      bad++;
      $display("FAIL frame_end d=%h done=%b busy=%b serial=%b want 1/0/1", d, tx_done, tx_busy, tx_serial);
    end
    @(negedge clk);
    total++;
    if (tx_done !== 1'b0) begin
      bad++;
      $display("FAIL done_width d=%h done=%b want 0", d, tx_done);
    end
    total++;
    if (busy_cnt != exp_len) begin
      bad++;
      $display("FAIL busy_len d=%h got=%0d want=%0d", d, busy_cnt, exp_len);
    end
  endtask

  // Second request at cycle 40 must neither corrupt nor queue.
  task automatic test_ignore_busy;
    int dones;
    build_wave(8'h3C);
    dones = 0;
    start_frame(8'h3C);
    for (int k = 0; k < exp_wave.size() + 12; k++) begin
      @(negedge clk);
      if (k == 0)  tx_start = 1'b0;
      if (k == 39) begin tx_start = 1'b1; tx_data = 8'hFF; end
      if (k == 40) begin tx_start = 1'b0; tx_data = 8'h00; end
      if (tx_done === 1'b1) dones++;
      if (k < exp_wave.size()) begin
        total++;
        if (tx_serial !== exp_wave[k]) begin
          bad++;
          $display("FAIL ignore_line cyc=%0d serial=%b want %b", k, tx_serial, exp_wave[k]);
        end
      end else if (k > exp_wave.size()) begin
        total++;
        if (tx_busy !== 1'b0 || tx_serial !== 1'b1) begin
          bad++;
          $display("FAIL ignore_queued cyc=%0d busy=%b serial=%b want 0/1", k, tx_busy, tx_serial);
        end
      end
    end
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL ignore_done_count got=%0d want=1", dones);
    end
  endtask

  // Reset 35 cycles into a frame, then a clean frame afterwards.
  task automatic test_reset_mid_frame;
    build_wave(8'h00);
    start_frame(8'h00);
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      if (k == 0) tx_start = 1'b0;
      total++;
      if (tx_serial !== exp_wave[k]) begin
        bad++;
        $display("FAIL abort_pre cyc=%0d serial=%b want %b", k, tx_serial, exp_wave[k]);
      end
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (tx_serial !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      bad++;
      $display("FAIL abort_immediate serial=%b busy=%b done=%b want 1/0/0", tx_serial, tx_busy, tx_done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
        bad++;
        $display("FAIL abort_after cyc=%0d serial=%b busy=%b done=%b want 1/0/0", k, tx_serial, tx_busy, tx_done);
      end
    end
    test_frame(8'h81);
  endtask

  // tx_start held high: one idle-high cycle between consecutive frames.
  task automatic test_back_to_back;
    build_wave(8'h55);
    start_frame(8'h55);
    for (int k = 0; k < exp_wave.size(); k++) begin
      @(negedge clk);
      total++;
      if (tx_serial !== exp_wave[k]) begin
        bad++;
        $display("FAIL b2b_first cyc=%0d serial=%b want %b", k, tx_serial, exp_wave[k]);
      end
    end
    @(negedge clk);
    total++;
    if (tx_serial !== 1'b1 || tx_done !== 1'b1 || tx_busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_gap serial=%b done=%b busy=%b want 1/1/0", tx_serial, tx_done, tx_busy);
    end
    for (int k = 0; k < exp_wave.size(); k++) begin
      @(negedge clk);
      if (k == 0) tx_start = 1'b0;
      total++;
      if (tx_serial !== exp_wave[k] || tx_busy !== 1'b1) begin
        bad++;
        $display("FAIL b2b_second cyc=%0d serial=%b busy=%b want %b/1", k, tx_serial, tx_busy, exp_wave[k]);
      end
    end
    @(negedge clk);
    total++;
    if (tx_done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second_done done=%b want 1", tx_done);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 4; n++) test_frame(DB'($urandom));
  endtask

`ifdef UART_TX_PARITY_EN
  // Sample the middle of the parity bit against hand-derived values.
  task automatic test_parity;
    logic [DB-1:0] pd [2];
    logic          pe [2];
    pd[0] = 8'h07; pe[0] = 1'b1;
    pd[1] = 8'h03; pe[1] = 1'b0;
    for (int t = 0; t < 2; t++) begin
      start_frame(pd[t]);
      for (int k = 0; k <= int'((DB + 3) * C); k++) begin
        @(negedge clk);
        if (k == 0) tx_start = 1'b0;
        if (k == int'((DB + 1) * C + C / 2)) begin
          total++;
          if (tx_serial !== pe[t]) begin
            bad++;
            $display("FAIL parity_bit d=%h got=%b want=%b", pd[t], tx_serial, pe[t]);
          end
        end
      end
      total++;
      if (tx_done !== 1'b1) begin
        bad++;
        $display("FAIL parity_frame_len d=%h done=%b want 1 at cycle 110", pd[t], tx_done);
      end
    end
    test_frame(8'h07);
  endtask
`endif

  initial begin
    test_reset();
    test_frame(8'hA5);
    test_ignore_busy();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
